// File: rtl/async_event_arbiter.sv
// Asynchronous event collector: per-line synchroniser and edge detector, sticky pending and
// overflow bits, and a round-robin valid/ack presenter for a single consumer.

module edge_detector #(
  parameter int OPTN_EDGE = 1
) (
  input  logic clk,
  input  logic n_rst,
  input  logic async_in,
  output logic pulse
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  // two-flop synchroniser followed by the edge-history flop
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      sync_p0 <= async_in;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  // history flop resets low, so a line held high through reset release gives one rising pulse
  assign pulse = (OPTN_EDGE != 0) ? (sync_p1 & ~prev_p2) : (~sync_p1 & prev_p2);

endmodule

module async_event_arbiter #(
  parameter int OPTN_NUM_EVENTS = 4,
  parameter int OPTN_EDGE       = 1,
  parameter int OPTN_ID_WIDTH   = $clog2(OPTN_NUM_EVENTS)
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic [OPTN_NUM_EVENTS-1:0] i_async_events,
  input  logic [OPTN_NUM_EVENTS-1:0] i_event_mask,
  output logic                       o_event_valid,
  output logic [OPTN_ID_WIDTH-1:0]   o_event_id,
  input  logic                       i_event_ack,
  output logic [OPTN_NUM_EVENTS-1:0] o_pending,
  output logic [OPTN_NUM_EVENTS-1:0] o_overflow,
  input  logic [OPTN_NUM_EVENTS-1:0] i_overflow_clear
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  localparam logic [OPTN_ID_WIDTH-1:0]   LAST_ID = OPTN_ID_WIDTH'(OPTN_NUM_EVENTS - 1);
  localparam logic [OPTN_NUM_EVENTS-1:0] ONE_HOT = OPTN_NUM_EVENTS'(1);

  state_t                     state_q;
  state_t                     state_d;
  logic [OPTN_ID_WIDTH-1:0]   ptr_q;
  logic [OPTN_ID_WIDTH-1:0]   next_ptr;
  logic [OPTN_NUM_EVENTS-1:0] pulse;
  logic [OPTN_NUM_EVENTS-1:0] pulse_m;
  logic [OPTN_NUM_EVENTS-1:0] eligible;
  logic [OPTN_NUM_EVENTS-1:0] ack_clr;
  logic [OPTN_NUM_EVENTS-1:0] pending_d;
  logic [OPTN_NUM_EVENTS-1:0] overflow_d;
  logic                       ack_fire;
  logic                       pick_found;
  logic [OPTN_ID_WIDTH-1:0]   pick_id;

  for (genvar g = 0; g < OPTN_NUM_EVENTS; g++) begin : g_det
    edge_detector #(
      .OPTN_EDGE(OPTN_EDGE)
    ) u_det (
      .clk     (clk),
      .n_rst   (n_rst),
      .async_in(i_async_events[g]),
      .pulse   (pulse[g])
    );
  end

  assign pulse_m  = pulse & i_event_mask;
  assign eligible = o_pending & i_event_mask;

  // round-robin search starting at ptr; wrap at N-1 is explicit so non-power-of-2 N works
  always_comb begin
    int idx;
    pick_found = 1'b0;
    pick_id    = '0;
    idx        = 0;
    for (int k = 0; k < OPTN_NUM_EVENTS; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= OPTN_NUM_EVENTS) idx = idx - OPTN_NUM_EVENTS;
      if (!pick_found && eligible[idx]) begin
        pick_found = 1'b1;
        pick_id    = idx[OPTN_ID_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ack_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) state_d = PRESENT;
      end
      PRESENT: begin
        if (i_event_ack) begin
          ack_fire = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign next_ptr = (o_event_id == LAST_ID) ? '0 : o_event_id + 1'b1;
  assign ack_clr  = ack_fire ? (ONE_HOT << o_event_id) : '0;

  // a new pulse re-pends the line even when the ack clears it in the same cycle
  assign pending_d = (o_pending & ~ack_clr) | pulse_m;

  // overflow set dominates a simultaneous clear
  assign overflow_d = (o_overflow & ~i_overflow_clear) | (pulse_m & o_pending & ~ack_clr);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      o_event_id <= '0;
      ptr_q      <= '0;
      o_pending  <= '0;
      o_overflow <= '0;
    end else begin
      state_q    <= state_d;
      o_pending  <= pending_d;
      o_overflow <= overflow_d;
      if (state_q == IDLE && pick_found) o_event_id <= pick_id;
      if (ack_fire) ptr_q <= next_ptr;
    end
  end

  assign o_event_valid = (state_q == PRESENT);

endmodule

// File: tb/tb_async_event_arbiter.sv
// Scoreboard bench for async_event_arbiter: expected ids queued as edges are driven,
// popped and compared when the arbiter presents them.

module tb_async_event_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          n_rst;
  logic [N-1:0]  ev;
  logic [N-1:0]  mask;
  logic          vld;
  logic [IW-1:0] id;
  logic          ack;
  logic [N-1:0]  pend;
  logic [N-1:0]  ovf;
  logic [N-1:0]  clr;

  int total = 0;
  int bad   = 0;
  logic [IW-1:0] sb[$];

  async_event_arbiter #(
    .OPTN_NUM_EVENTS(N),
    .OPTN_EDGE      (1),
    .OPTN_ID_WIDTH  (IW)
  ) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .i_async_events  (ev),
    .i_event_mask    (mask),
    .o_event_valid   (vld),
    .o_event_id      (id),
    .i_event_ack     (ack),
    .o_pending       (pend),
    .o_overflow      (ovf),
    .i_overflow_clear(clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_pending(input string tag, input int line);
    int n = 0;
    while (!pend[line] && n < 8) begin
      tick(1);
      n++;
    end
    chk({tag, "_pend_seen"}, 32'(pend[line]), 1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!vld && n < 20) begin
      tick(1);
      n++;
    end
    chk({tag, "_vld_seen"}, 32'(vld), 1);
  endtask

  task automatic serve(input string tag);
    logic [IW-1:0] e;
    wait_valid(tag);
    if (!vld) return;
    if (sb.size() == 0) begin
      chk({tag, "_unexpected"}, 1, 0);
      e = id;
    end else begin
      e = sb.pop_front();
    end
    chk({tag, "_id"}, 32'(id), 32'(e));
    tick(2);
    chk({tag, "_hold"}, {29'd0, vld, id}, {29'd0, 1'b1, e});
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk({tag, "_vld_drop"}, 32'(vld), 0);
    chk({tag, "_pend_clr"}, 32'(pend[e]), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst = 1'b0;
    ev    = '0;
    mask  = '1;
    ack   = 1'b0;
    clr   = '0;
    tick(3);
    chk("rst_outputs", {vld, id, pend, ovf}, '0);
    n_rst = 1'b1;
    tick(2);

    // single event on line 2
    ev[2] = 1'b1;
    sb.push_back(2'd2);
    wait_pending("t1", 2);
    chk("t1_pend", 32'(pend), 32'b0100);
    serve("t1");
    chk("t1_pend_after", 32'(pend), 0);

    // move ptr to 0 through an ack of id 3
    ev[3] = 1'b1;
    sb.push_back(2'd3);
    serve("t2pre");
    ev = '0;
    tick(5);

    // simultaneous lines 0,1,3 from ptr 0
    ev = 4'b1011;
    sb.push_back(2'd0);
    sb.push_back(2'd1);
    sb.push_back(2'd3);
    wait_pending("t2", 0);
    chk("t2_pend", 32'(pend), 32'b1011);
    serve("t2a");
    serve("t2b");
    serve("t2c");

    // wrap fairness after id 3
    ev = '0;
    tick(4);
    ev = 4'b1001;
    sb.push_back(2'd0);
    sb.push_back(2'd3);
    serve("t3a");
    serve("t3b");

    // overflow on line 1
    ev = '0;
    tick(4);
    ev[1] = 1'b1;
    wait_valid("t4");
    chk("t4_id", 32'(id), 1);
    ev[1] = 1'b0;
    tick(4);
    ev[1] = 1'b1;
    tick(5);
    chk("t4_ovf_set", 32'(ovf), 32'b0010);
    chk("t4_pend", 32'(pend), 32'b0010);
    clr = 4'b0010;
    tick(1);
    clr = '0;
    chk("t4_ovf_clr", 32'(ovf), 0);
    ev[1] = 1'b0;
    tick(4);
    ev[1] = 1'b1;
    tick(2);
    clr = 4'b0010;
    tick(1);
    clr = '0;
    chk("t4_set_wins", 32'(ovf), 32'b0010);
    clr = 4'b0010;
    tick(1);
    clr = '0;
    chk("t4_ovf_clr2", 32'(ovf), 0);
    ev[1] = 1'b0;
    tick(4);
    ev[1] = 1'b1;
    tick(2);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("t4_ack_repend", 32'(pend), 32'b0010);
    chk("t4_ack_noovf", 32'(ovf), 0);
    chk("t4_ack_vld", 32'(vld), 0);
    sb.push_back(2'd1);
    serve("t4b");

    // masked line drops edges
    ev = '0;
    tick(4);
    mask = 4'b1011;
    ev[2] = 1'b1;
    tick(5);
    ev[2] = 1'b0;
    tick(4);
    chk("t5_masked", {vld, pend, ovf}, '0);
    mask = '1;
    tick(3);
    chk("t5_unmask", {vld, pend}, '0);

    // masking a presented line does not retract it
    ev[0] = 1'b1;
    sb.push_back(2'd0);
    wait_valid("t5b");
    mask = 4'b1110;
    tick(3);
    chk("t5_masked_hold", {29'd0, vld, id}, {29'd0, 1'b1, 2'd0});
    serve("t5b");
    mask = '1;

    // reset during PRESENT, line 3 held high through release
    ev = '0;
    tick(4);
    ev = 4'b1011;
    wait_pending("t6", 0);
    tick(3);
    chk("t6_vld", 32'(vld), 1);
    chk("t6_pend", 32'(pend), 32'b1011);
    n_rst = 1'b0;
    ev = 4'b1000;
    tick(1);
    chk("t6_rst", {vld, id, pend, ovf}, '0);
    tick(2);
    n_rst = 1'b1;
    sb.push_back(2'd3);
    serve("t6");
    tick(10);
    chk("t6_single", {vld, pend}, '0);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
